race_arbiter_bank: RTL and testbench

//  Clocked, multi-channel successor to the single-pair race arbiter. Arbitrates N_CH

---
 rtl/race_arbiter_bank_if.sv | 25 ++
 rtl/race_arbiter_bank.sv | 145 ++++++++++++++
 tb/tb_race_arbiter_bank.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/race_arbiter_bank_if.sv
// Challenge/response bus of the multi-channel race arbiter: race inputs, start and the
// valid/ready result handshake.
interface race_arbiter_bank_if #(
   parameter int unsigned N_CH = 8
);
   logic            start;
   logic [N_CH-1:0] finished_a;
   logic [N_CH-1:0] finished_b;
   logic            busy;
   logic            resp_valid;
   logic            resp_ready;
   logic [N_CH-1:0] response;
   logic [N_CH-1:0] tie;
   logic [N_CH-1:0] timed_out;

   modport master (
      output start, finished_a, finished_b, resp_ready,
      input  busy, resp_valid, response, tie, timed_out
   );

   modport slave (
      input  start, finished_a, finished_b, resp_ready,
      output busy, resp_valid, response, tie, timed_out
   );
endinterface

// File: rtl/race_arbiter_bank.sv
// Arbitrates N_CH PUF delay-line pairs in parallel: synchronises arrivals, resolves the
// winner per channel with tie/timeout detection and returns the word over valid/ready.
module race_arbiter_bank #(
   parameter int unsigned N_CH        = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 255,
   parameter bit          TIE_VAL     = 1'b0
) (
   input  logic                clk,
   input  logic                reset_n,
   race_arbiter_bank_if.slave  bus
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ARM, RACE, DONE} state_t;

   state_t state, state_d;

   logic [SYNC_STAGES-1:0][N_CH-1:0] sync_a, sync_b;
   logic [N_CH-1:0] sa, sb;
   logic [TW-1:0]   timer, timer_d;
   logic [N_CH-1:0] resolved, resolved_d;
   logic [N_CH-1:0] response_d, tie_d, timed_out_d;
   logic            busy_d, valid_d;
   logic            timer_last, lines_idle, all_resolved;

   // Input synchronisers; the raw pins feed nothing else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a[0] <= bus.finished_a;
         sync_b[0] <= bus.finished_b;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_a[s] <= sync_a[s-1];
            sync_b[s] <= sync_b[s-1];
         end
      end
   end

   assign sa           = sync_a[SYNC_STAGES-1];
   assign sb           = sync_b[SYNC_STAGES-1];
   assign timer_last   = (timer == T_LAST);
   assign lines_idle   = ~|(sa | sb);
   assign all_resolved = &(resolved | sa | sb);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_d;
   end

   // Next state; a line reset in the last ARM cycle still wins over the timeout
   always_comb begin
      state_d = state;
      case (state)
         IDLE: if (bus.start) state_d = ARM;
         ARM: begin
            if (lines_idle)      state_d = RACE;
            else if (timer_last) state_d = DONE;
         end
         RACE: if (all_resolved || timer_last) state_d = DONE;
         DONE: if (bus.resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs, resolved mask and timer
   always_comb begin
      response_d  = bus.response;
      tie_d       = bus.tie;
      timed_out_d = bus.timed_out;
      resolved_d  = resolved;
      busy_d      = (state_d != IDLE);
      valid_d     = (state_d == DONE);
      if (state_d != state)
         timer_d = '0;
      else if (state == ARM || state == RACE)
         timer_d = timer + TW'(1);
      else
         timer_d = timer;

      case (state)
         IDLE: begin
            if (bus.start) begin
               response_d  = '0;
               tie_d       = '0;
               timed_out_d = '0;
               resolved_d  = '0;
            end
         end
         ARM: begin
            if (!lines_idle && timer_last) begin
               timed_out_d = '1;
               response_d  = {N_CH{TIE_VAL}};
               tie_d       = '0;
            end
         end
         RACE: begin
            for (int unsigned i = 0; i < N_CH; i++) begin
               if (!resolved[i]) begin
                  if (sa[i] && sb[i]) begin
                     response_d[i] = TIE_VAL;
                     tie_d[i]      = 1'b1;
                     resolved_d[i] = 1'b1;
                  end else if (sa[i]) begin
                     response_d[i] = 1'b1;
                     resolved_d[i] = 1'b1;
                  end else if (sb[i]) begin
                     response_d[i] = 1'b0;
                     resolved_d[i] = 1'b1;
                  end else if (timer_last) begin
                     response_d[i]  = TIE_VAL;
                     timed_out_d[i] = 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer          <= '0;
         resolved       <= '0;
         bus.response   <= '0;
         bus.tie        <= '0;
         bus.timed_out  <= '0;
         bus.busy       <= 1'b0;
         bus.resp_valid <= 1'b0;
      end else begin
         timer          <= timer_d;
         resolved       <= resolved_d;
         bus.response   <= response_d;
         bus.tie        <= tie_d;
         bus.timed_out  <= timed_out_d;
         bus.busy       <= busy_d;
         bus.resp_valid <= valid_d;
      end
   end

endmodule

// File: tb/tb_race_arbiter_bank.sv
// Directed bench for race_arbiter_bank: two instances (TIE_VAL 0 and 1, TIMEOUT 16)
// share one stimulus stream and are checked against hand-computed results.
module tb_race_arbiter_bank;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   int   lat;

   race_arbiter_bank_if #(.N_CH(8)) bus0 ();
   race_arbiter_bank_if #(.N_CH(8)) bus1 ();

   assign bus1.start      = bus0.start;
   assign bus1.finished_a = bus0.finished_a;
   assign bus1.finished_b = bus0.finished_b;
   assign bus1.resp_ready = bus0.resp_ready;

   race_arbiter_bank #(.N_CH(8), .SYNC_STAGES(2), .TIMEOUT(16), .TIE_VAL(1'b0)) dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus0)
   );

   race_arbiter_bank #(.N_CH(8), .SYNC_STAGES(2), .TIMEOUT(16), .TIE_VAL(1'b1)) dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic [7:0] r0, input logic [7:0] r1,
                          input logic [7:0] t, input logic [7:0] to);
      chk({tag, ".resp0"}, 32'(bus0.response), 32'(r0));
      chk({tag, ".resp1"}, 32'(bus1.response), 32'(r1));
      chk({tag, ".tie0"},  32'(bus0.tie),      32'(t));
      chk({tag, ".tie1"},  32'(bus1.tie),      32'(t));
      chk({tag, ".to0"},   32'(bus0.timed_out), 32'(to));
      chk({tag, ".to1"},   32'(bus1.timed_out), 32'(to));
   endtask

   task automatic chk_ctl(input string tag, input logic busy, input logic valid);
      chk({tag, ".busy0"},  32'(bus0.busy),       32'(busy));
      chk({tag, ".busy1"},  32'(bus1.busy),       32'(busy));
      chk({tag, ".valid0"}, 32'(bus0.resp_valid), 32'(valid));
      chk({tag, ".valid1"}, 32'(bus1.resp_valid), 32'(valid));
   endtask

   // Pulse start from IDLE; returns just after the edge that enters ARM
   task automatic start_pulse();
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
   endtask

   // Bounded wait for resp_valid; cnt = edges waited
   task automatic wait_valid(input int max, output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!bus0.resp_valid && cnt < max);
   endtask

   task automatic accept();
      bus0.resp_ready = 1'b1;
      tick();
      bus0.resp_ready = 1'b0;
   endtask

   task automatic set_lines(input logic [7:0] a, input logic [7:0] b);
      bus0.finished_a = a;
      bus0.finished_b = b;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      checks          = 0;
      errors          = 0;
      reset_n         = 1'b0;
      bus0.start      = 1'b0;
      bus0.resp_ready = 1'b0;
      set_lines(8'h00, 8'h00);

      // 1: reset with inputs toggling
      for (int i = 0; i < 4; i++) begin
         set_lines(8'($urandom), 8'($urandom));
         bus0.start      = 1'(i);
         bus0.resp_ready = 1'b1;
         tick();
      end
      chk_ctl("rst", 1'b0, 1'b0);
      chk_res("rst", 8'h00, 8'h00, 8'h00, 8'h00);
      bus0.start      = 1'b0;
      bus0.resp_ready = 1'b0;
      set_lines(8'h00, 8'h00);
      reset_n = 1'b1;
      tick(3);
      chk_ctl("idle", 1'b0, 1'b0);

      // 2: A on ch0-3 three cycles before B on ch4-7, then everything high
      start_pulse();
      chk_ctl("arm", 1'b1, 1'b0);
      set_lines(8'h0F, 8'h00);
      tick(3);
      set_lines(8'h0F, 8'hF0);
      tick();
      set_lines(8'hFF, 8'hFF);
      wait_valid(40, lat);
      chk("split.lat", 32'(lat), 32'd2);
      chk_ctl("split", 1'b1, 1'b1);
      chk_res("split", 8'h0F, 8'h0F, 8'h00, 8'h00);
      accept();
      chk_ctl("split.acc", 1'b0, 1'b0);
      chk("split.hold", 32'(bus0.response), 32'h0F);

      // 3: ch0 tie, ch1-7 A first; minimum latency after ARM
      set_lines(8'h00, 8'h00);
      tick(3);
      start_pulse();
      set_lines(8'hFF, 8'h01);
      wait_valid(40, lat);
      chk("tie.lat", 32'(lat), 32'd3);
      chk_res("tie", 8'hFE, 8'hFF, 8'h01, 8'h00);
      accept();

      // 4: race timeout, ch0-3 early and ch4 exactly in the final RACE cycle
      set_lines(8'h00, 8'h00);
      tick(3);
      start_pulse();
      set_lines(8'h0F, 8'h00);
      tick(14);
      chk_ctl("to.race", 1'b1, 1'b0);
      set_lines(8'h1F, 8'h00);
      wait_valid(40, lat);
      chk("to.lat", 32'(lat), 32'd3);
      chk_res("to", 8'h1F, 8'hFF, 8'h00, 8'hE0);
      accept();

      // 5a: lines never reset -> ARM timeout
      set_lines(8'hFF, 8'hFF);
      tick(3);
      start_pulse();
      wait_valid(40, lat);
      chk("arm_to.lat", 32'(lat), 32'd16);
      chk_res("arm_to", 8'h00, 8'hFF, 8'h00, 8'hFF);
      accept();

      // 5b: lines drop late, RACE then proceeds normally
      start_pulse();
      tick(4);
      set_lines(8'h00, 8'h00);
      tick(3);
      chk_ctl("late", 1'b1, 1'b0);
      set_lines(8'hAA, 8'h55);
      wait_valid(40, lat);
      chk("late.lat", 32'(lat), 32'd3);
      chk_res("late", 8'hAA, 8'hAA, 8'h00, 8'h00);

      // 6: back-pressure in DONE with noise on every input
      for (int i = 0; i < 10; i++) begin
         set_lines(8'($urandom), 8'($urandom));
         bus0.start = 1'((i + 1) % 2);
         tick();
         chk_ctl("bp", 1'b1, 1'b1);
         chk("bp.resp0", 32'(bus0.response), 32'hAA);
         chk("bp.resp1", 32'(bus1.response), 32'hAA);
      end
      bus0.start = 1'b0;
      accept();
      chk_ctl("bp.acc", 1'b0, 1'b0);
      chk_res("bp.idle", 8'hAA, 8'hAA, 8'h00, 8'h00);

      // 6b: reset in the middle of a race
      set_lines(8'h00, 8'h00);
      tick(3);
      start_pulse();
      tick();
      set_lines(8'hFF, 8'h00);
      tick(2);
      chk_ctl("abort.pre", 1'b1, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      chk_ctl("abort", 1'b0, 1'b0);
      chk_res("abort", 8'h00, 8'h00, 8'h00, 8'h00);
      #1 reset_n = 1'b1;
      tick(5);
      chk_ctl("abort.post", 1'b0, 1'b0);
      chk("abort.resp", 32'(bus0.response), 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
